// File: rtl/aes128_enc_iter_pkg.sv
// aes128_enc_iter_pkg: FSM states and GF(2^8) helpers shared by the iterative AES-128 core
package aes128_enc_iter_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SUB, SMA, DONE} state_e;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = xtime(x);
    end
    return p;
  endfunction
  // Multiplicative inverse as x^254 (0 maps to 0), then the FIPS-197 affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq = x;
    inv = 8'h01;
    for (int k = 0; k < 7; k++) begin
      sq = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [31:0] mixcol(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction
  function automatic logic [7:0] rcon(input logic [3:0] i);
    return i == 4'd9 ? 8'h1b : i == 4'd10 ? 8'h36 : (i != 4'd0 && i < 4'd9) ? 8'(32'd1 << (i - 4'd1)) : 8'h00;
  endfunction
  function automatic logic [127:0] key_next(input logic [127:0] rk, input logic [31:0] sw, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = rk[127:96] ^ sw ^ {rc, 24'h0};
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction
endpackage

// File: rtl/aes128_enc_iter_sbox.sv
// aes128_enc_iter_sbox: combinational AES S-box, zero-cycle latency
module aes128_enc_iter_sbox
  import aes128_enc_iter_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  assign o_byte = sbox(i_byte);
endmodule

// File: rtl/aes128_enc_iter.sv
// aes128_enc_iter: iterative AES-128 encryptor, SBOX_PAR state bytes substituted per cycle,
// round keys expanded on the fly, valid/ready on both sides.
module aes128_enc_iter
  import aes128_enc_iter_pkg::*;
#(
  parameter int SBOX_PAR   = 16,
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy
);
  localparam int NCH = 16 / SBOX_PAR;
  localparam int W = 8 * SBOX_PAR;
  if (!(SBOX_PAR == 1 || SBOX_PAR == 2 || SBOX_PAR == 4 || SBOX_PAR == 8 || SBOX_PAR == 16))
    $error("SBOX_PAR must be one of 1,2,4,8,16");
  if (NUM_ROUNDS != 10)
    $error("NUM_ROUNDS must be 10");
  state_e       r_fsm;
  logic [127:0] r_state;
  logic [127:0] r_rk;
  logic [3:0]   r_round;
  logic [3:0]   r_bctr;
  logic         r_out_valid;
  logic [127:0] r_out_block;
  logic [6:0]   w_msb;
  logic [W-1:0] w_chunk;
  logic [W-1:0] w_sub;
  logic [31:0]  w_rot;
  logic [31:0]  w_sw;
  logic [127:0] w_rk_next;
  logic [127:0] w_sr;
  logic [127:0] w_mc;
  logic [127:0] w_sma;
  logic         w_last;
  assign w_msb   = 7'(127 - W * int'(r_bctr));
  assign w_chunk = r_state[w_msb -: W];
  assign w_last  = r_bctr == 4'(NCH - 1);
  for (genvar g = 0; g < SBOX_PAR; g++) begin : g_sub
    aes128_enc_iter_sbox u_sbox (.i_byte(w_chunk[W-1-8*g -: 8]), .o_byte(w_sub[W-1-8*g -: 8]));
  end
  // Key schedule: SubWord(RotWord(w3)) through four dedicated S-boxes
  assign w_rot = {r_rk[23:0], r_rk[31:24]};
  for (genvar k = 0; k < 4; k++) begin : g_key
    aes128_enc_iter_sbox u_sbox (.i_byte(w_rot[31-8*k -: 8]), .o_byte(w_sw[31-8*k -: 8]));
  end
  assign w_rk_next = key_next(r_rk, w_sw, rcon(r_fsm == LOAD ? 4'd1 : r_round + 4'd1));
  // ShiftRows: s'[r][c] = s[r][(c+r)%4], byte index r+4c
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign w_sr[127-8*(r+4*c) -: 8] = r_state[127-8*(r+4*((c+r)%4)) -: 8];
    end
    assign w_mc[127-32*c -: 32] = mixcol(w_sr[127-32*c -: 32]);
  end
  assign w_sma = (r_round == 4'(NUM_ROUNDS) ? w_sr : w_mc) ^ r_rk;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm       <= IDLE;
      r_state     <= '0;
      r_rk        <= '0;
      r_round     <= '0;
      r_bctr      <= '0;
      r_out_valid <= 1'b0;
      r_out_block <= '0;
    end else begin
      case (r_fsm)
        IDLE: if (in_valid) begin
          r_state <= in_block ^ in_key;
          r_rk    <= in_key;
          r_fsm   <= LOAD;
        end
        LOAD: begin
          r_round <= 4'd1;
          r_rk    <= w_rk_next;
          r_bctr  <= '0;
          r_fsm   <= SUB;
        end
        SUB: begin
          r_state[w_msb -: W] <= w_sub;
          r_bctr <= w_last ? 4'd0 : r_bctr + 4'd1;
          if (w_last) r_fsm <= SMA;
        end
        SMA: begin
          r_state <= w_sma;
          r_rk    <= w_rk_next;
          if (r_round == 4'(NUM_ROUNDS)) r_fsm <= DONE;
          else begin
            r_round <= r_round + 4'd1;
            r_fsm   <= SUB;
          end
        end
        DONE: if (!r_out_valid) begin
          r_out_valid <= 1'b1;
          r_out_block <= r_state;
        end else if (out_ready) begin
          r_out_valid <= 1'b0;
          r_fsm       <= IDLE;
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end
  assign in_ready  = r_fsm == IDLE;
  assign busy      = r_fsm != IDLE;
  assign out_valid = r_out_valid;
  assign out_block = r_out_block;
endmodule
